// File: rtl/line_mem_if.sv
// Line-request bus between a requester and line_mem_responder.
// The requester holds address, direction and write data stable from valid until ready.
interface line_mem_if #(
    parameter int ADDR_W = 17,
    parameter int LINE_W = 128
);
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_valid;
    logic              mem_req_wr;
    logic [LINE_W-1:0] mem_wr_data;
    logic [LINE_W-1:0] mem_rd_data;
    logic              mem_req_ready;

    modport master (
        output mem_req_addr,
        output mem_req_valid,
        output mem_req_wr,
        output mem_wr_data,
        input  mem_rd_data,
        input  mem_req_ready
    );

    modport slave (
        input  mem_req_addr,
        input  mem_req_valid,
        input  mem_req_wr,
        input  mem_wr_data,
        output mem_rd_data,
        output mem_req_ready
    );
endinterface

// File: rtl/line_mem_responder.sv
// Splits 128-bit line reads/writes into four 32-bit beats on a word memory
// with one cycle of read latency.
//
// state   | meaning
// IDLE    | waiting for a request; accepts on the edge where valid is seen
// WR      | issuing write beats 0..3
// RD      | issuing read beats 0..3, capturing the previous beat's word
// RD_LAST | capturing the fourth read word, no memory access
// DONE    | one-cycle completion pulse on mem_req_ready
module line_mem_responder #(
    parameter int ADDR_W = 17,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    line_mem_if.slave         bus,
    output logic              busy,
    output logic              wd_en,
    output logic              wd_we,
    output logic [ADDR_W-3:0] wd_addr,
    output logic [31:0]       wd_wdata,
    input  logic [31:0]       wd_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD      = 3'd2,
        RD_LAST = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state;
    logic [1:0]        beat;
    logic [1:0]        beat_nxt;
    logic [1:0]        beat_prev;
    logic [ADDR_W-5:0] line_q;
    logic [LINE_W-1:0] data_q;
    logic              unused_addr_lsb;

    assign beat_nxt        = beat + 2'd1;
    assign beat_prev       = beat - 2'd1;
    assign unused_addr_lsb = ^bus.mem_req_addr[3:0];

    // beat_prev wraps to 3 in RD_LAST (beat is 0 there), so the same
    // capture expression serves both RD and RD_LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            beat              <= 2'd0;
            line_q            <= '0;
            data_q            <= '0;
            busy              <= 1'b0;
            wd_en             <= 1'b0;
            wd_we             <= 1'b0;
            wd_addr           <= '0;
            wd_wdata          <= '0;
            bus.mem_req_ready <= 1'b0;
            bus.mem_rd_data   <= '0;
        end else begin
            bus.mem_req_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.mem_req_valid) begin
                        line_q  <= bus.mem_req_addr[ADDR_W-1:4];
                        data_q  <= bus.mem_wr_data;
                        beat    <= 2'd0;
                        busy    <= 1'b1;
                        wd_en   <= 1'b1;
                        wd_we   <= bus.mem_req_wr;
                        wd_addr <= {bus.mem_req_addr[ADDR_W-1:4], 2'd0};
                        if (bus.mem_req_wr) begin
                            wd_wdata <= bus.mem_wr_data[31:0];
                            state    <= WR;
                        end else begin
                            state    <= RD;
                        end
                    end
                end
                WR: begin
                    beat <= beat_nxt;
                    if (beat == 2'd3) begin
                        state             <= DONE;
                        wd_en             <= 1'b0;
                        wd_we             <= 1'b0;
                        bus.mem_req_ready <= 1'b1;
                    end else begin
                        wd_addr  <= {line_q, beat_nxt};
                        wd_wdata <= data_q[{beat_nxt, 5'd0} +: 32];
                    end
                end
                RD: begin
                    beat <= beat_nxt;
                    if (beat != 2'd0) begin
                        bus.mem_rd_data[{beat_prev, 5'd0} +: 32] <= wd_rdata;
                    end
                    if (beat == 2'd3) begin
                        state <= RD_LAST;
                        wd_en <= 1'b0;
                    end else begin
                        wd_addr <= {line_q, beat_nxt};
                    end
                end
                RD_LAST: begin
                    bus.mem_rd_data[{beat_prev, 5'd0} +: 32] <= wd_rdata;
                    state             <= DONE;
                    bus.mem_req_ready <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    beat  <= 2'd0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    wd_en <= 1'b0;
                    wd_we <= 1'b0;
                    beat  <= 2'd0;
                end
            endcase
        end
    end

endmodule
